// File: rtl/csi2_lane_pkg.sv
// Shared types and constants for the CSI-2 D-PHY data-lane HS burst sequencer.
package csi2_lane_pkg;

    localparam int unsigned DWELL_W   = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        STOP,
        HS_RQST,
        HS_PREP,
        HS_ZERO,
        SYNC,
        DATA,
        TRAIL
    } lane_state_e;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

endpackage

// File: rtl/csi2_lane_hs_sequencer_ser.sv
// Byte load/shift register for the lane serialiser; bit0 of the held byte is the bit on the wire.
module csi2_lane_ser
    import csi2_lane_pkg::*;
(
    input  logic                 clk_p_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [7:0]           byte_i,
    output logic                 bit_o,
    output logic                 nxt_bit_c,
    output logic [BIT_IDX_W-1:0] idx_o
);

    logic [7:0]           r_shift;
    logic [BIT_IDX_W-1:0] r_idx;

    always_ff @(posedge clk_p_i) begin
        if (!rst_n_i) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (load_i) begin
            r_shift <= byte_i;
            r_idx   <= '0;
        end else if (shift_i) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_idx   <= r_idx + BIT_IDX_W'(1);
        end
    end

    // Bit that will be on the wire after the coming edge, used to register the pins.
    assign nxt_bit_c = load_i ? byte_i[0] : (shift_i ? r_shift[1] : r_shift[0]);
    assign bit_o     = r_shift[0];
    assign idx_o     = r_idx;

endmodule

// File: rtl/csi2_lane_hs_sequencer.sv
// One D-PHY data lane: LP entry, HS-zero, sync, LSB-first payload, trail, LP-11 stop.
// Optional burst/underrun statistics counters under CSI2_LANE_SEQ_STATS_EN.
module csi2_lane_hs_sequencer
    import csi2_lane_pkg::*;
#(
    parameter int          CH        = 0,
    parameter int unsigned T_LPX     = 8,
    parameter int unsigned T_HS_ZERO = 16,
    parameter int unsigned T_TRAIL   = 8,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic        clk_p_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        last_i,
    output logic        byte_ready_o,
    output logic        do_p_o,
    output logic        do_n_o,
    output logic        hs_active_o,
    output logic        busy_o,
`ifdef CSI2_LANE_SEQ_STATS_EN
    output logic [15:0] burst_cnt_o,
    output logic [15:0] underrun_cnt_o,
`endif
    output logic        underrun_o
);

    localparam logic [DWELL_W-1:0] LPX_LD   = DWELL_W'(T_LPX - 1);
    localparam logic [DWELL_W-1:0] ZERO_LD  = DWELL_W'(T_HS_ZERO - 1);
    localparam logic [DWELL_W-1:0] TRAIL_LD = DWELL_W'(T_TRAIL - 1);

    if (CH < 0 || T_LPX < 1 || T_LPX > 255 || T_HS_ZERO < 1 || T_HS_ZERO > 255
        || T_TRAIL < 1 || T_TRAIL > 255) begin : g_bad_param
        $error("csi2 lane %0d: timing parameter out of range 1..255", CH);
    end

    lane_state_e          r_state, w_state_nxt;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
    logic                 r_last_acc, w_last_nxt;
    logic                 r_ready, r_do_p, r_do_n, r_hs, r_busy;
    logic                 w_ready_nxt, w_hs_nxt, w_busy_nxt;
    logic [1:0]           w_pins_nxt;
    logic                 w_load, w_shift, w_accept, w_underrun, w_dwell_zero;
    logic [7:0]           w_load_byte;
    logic                 w_ser_bit, w_ser_nxt_bit;
    logic [BIT_IDX_W-1:0] w_idx;

    assign w_accept     = byte_valid_i & r_ready;
    assign w_underrun   = r_ready & ~byte_valid_i;
    assign w_dwell_zero = (r_dwell == '0);
    assign w_load_byte  = (r_state == HS_ZERO) ? SYNC_BYTE : byte_i;

    csi2_lane_ser u_ser (
        .clk_p_i   (clk_p_i),
        .rst_n_i   (rst_n_i),
        .load_i    (w_load),
        .shift_i   (w_shift),
        .byte_i    (w_load_byte),
        .bit_o     (w_ser_bit),
        .nxt_bit_c (w_ser_nxt_bit),
        .idx_o     (w_idx)
    );

    // State, dwell counter and registered lane outputs.
    always_ff @(posedge clk_p_i) begin
        if (!rst_n_i) begin
            r_state    <= STOP;
            r_dwell    <= '0;
            r_last_acc <= 1'b0;
            r_ready    <= 1'b0;
            r_do_p     <= 1'b1;
            r_do_n     <= 1'b1;
            r_hs       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_dwell          <= w_dwell_nxt;
            r_last_acc       <= w_last_nxt;
            r_ready          <= w_ready_nxt;
            {r_do_p, r_do_n} <= w_pins_nxt;
            r_hs             <= w_hs_nxt;
            r_busy           <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = w_dwell_zero ? r_dwell : r_dwell - DWELL_W'(1);
        w_last_nxt  = r_last_acc;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_pins_nxt  = LP11;
        w_hs_nxt    = 1'b0;

        unique case (r_state)
            STOP: if (w_dwell_zero && start_i) begin
                w_state_nxt = HS_RQST;
                w_dwell_nxt = LPX_LD;
            end
            HS_RQST: if (w_dwell_zero) begin
                w_state_nxt = HS_PREP;
                w_dwell_nxt = LPX_LD;
            end
            HS_PREP: if (w_dwell_zero) begin
                w_state_nxt = HS_ZERO;
                w_dwell_nxt = ZERO_LD;
            end
            HS_ZERO: if (w_dwell_zero) begin
                w_state_nxt = SYNC;
                w_load      = 1'b1;
                w_last_nxt  = 1'b0;
            end
            // Bit 7 is the load slot: a fresh byte keeps the stream gapless, otherwise trail.
            SYNC, DATA: begin
                if (w_idx != BIT_IDX_W'(7)) begin
                    w_shift = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = DATA;
                    w_load      = 1'b1;
                    w_last_nxt  = last_i;
                end else begin
                    w_state_nxt = TRAIL;
                    w_dwell_nxt = TRAIL_LD;
                end
            end
            TRAIL: if (w_dwell_zero) begin
                w_state_nxt = STOP;
                w_dwell_nxt = LPX_LD;
            end
            default: w_state_nxt = STOP;
        endcase

        unique case (w_state_nxt)
            HS_RQST: w_pins_nxt = LP01;
            HS_PREP: w_pins_nxt = LP00;
            HS_ZERO: begin
                w_pins_nxt = LP01;
                w_hs_nxt   = 1'b1;
            end
            SYNC, DATA: begin
                w_pins_nxt = {w_ser_nxt_bit, ~w_ser_nxt_bit};
                w_hs_nxt   = 1'b1;
            end
            TRAIL: begin
                w_pins_nxt = {~w_ser_bit, w_ser_bit};
                w_hs_nxt   = 1'b1;
            end
            default: w_pins_nxt = LP11;
        endcase

        w_ready_nxt = ((r_state == SYNC) || (r_state == DATA)) && (w_idx == BIT_IDX_W'(6))
                      && !r_last_acc;
        w_busy_nxt  = !((w_state_nxt == STOP) && (w_dwell_nxt == '0));
    end

    assign byte_ready_o = r_ready;
    assign do_p_o       = r_do_p;
    assign do_n_o       = r_do_n;
    assign hs_active_o  = r_hs;
    assign busy_o       = r_busy;
    assign underrun_o   = w_underrun;

`ifdef CSI2_LANE_SEQ_STATS_EN
    logic [15:0] r_burst_cnt, r_underrun_cnt;

    // Saturating statistics counters.
    always_ff @(posedge clk_p_i) begin
        if (!rst_n_i) begin
            r_burst_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if ((w_state_nxt == TRAIL) && (r_state != TRAIL) && (r_burst_cnt != 16'hFFFF))
                r_burst_cnt <= r_burst_cnt + 16'd1;
            if (w_underrun && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign burst_cnt_o    = r_burst_cnt;
    assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule
